// File: rtl/stage_if.sv
// stage_if: instruction fetch stage, single-word Wishbone classic reads with redirect squash.
module stage_if #(
    parameter logic [31:0] RESET_ADDR = 32'h80000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        br_j_taken_i,
    input  logic [31:0] br_j_addr_i,
    input  logic        stall_i,
    output logic [31:0] iwbm_addr_o,
    output logic        iwbm_cyc_o,
    output logic        iwbm_stb_o,
    output logic        iwbm_we_o,
    output logic [3:0]  iwbm_sel_o,
    input  logic [31:0] iwbm_dat_i,
    input  logic        iwbm_ack_i,
    input  logic        iwbm_err_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        e_inst_access_fault_o
);
    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
    state_t state, state_n;
    logic [31:0] pc, pc_n, hold, hold_n, inst_n, pc_out_n, target;
    logic valid_n, fault_n, redirect, consume, resp;
    assign redirect = br_j_taken_i;
    assign consume = valid_o & ~stall_i;
    assign resp = iwbm_ack_i | iwbm_err_i;
    assign target = br_j_addr_i & 32'hFFFF_FFFC;
    assign iwbm_cyc_o = state != IDLE;
    assign iwbm_stb_o = iwbm_cyc_o;
    assign iwbm_we_o = 1'b0;
    assign iwbm_sel_o = 4'hF;
    // a squashed request keeps its original address until the slave answers
    assign iwbm_addr_o = state == DISCARD ? hold : {pc[31:2], 2'b00};
    always_comb begin
        state_n = state;
        pc_n = pc;
        hold_n = hold;
        inst_n = inst_o;
        pc_out_n = pc_o;
        valid_n = valid_o;
        fault_n = e_inst_access_fault_o;
        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_n = target;
                    valid_n = 1'b0;
                    state_n = FETCH;
                end else if (!valid_o || consume) begin
                    valid_n = 1'b0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_n = target;
                    hold_n = {pc[31:2], 2'b00};
                    state_n = resp ? IDLE : DISCARD;
                end else if (resp) begin
                    inst_n = iwbm_err_i ? 32'h00000013 : iwbm_dat_i;
                    pc_out_n = pc;
                    valid_n = 1'b1;
                    fault_n = iwbm_err_i;
                    pc_n = iwbm_err_i ? pc : pc + 32'd4;
                    state_n = IDLE;
                end
            end
            DISCARD: begin
                pc_n = redirect ? target : pc;
                state_n = resp ? IDLE : DISCARD;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            pc <= RESET_ADDR;
            hold <= RESET_ADDR;
            inst_o <= 32'h00000013;
            pc_o <= '0;
            valid_o <= 1'b0;
            e_inst_access_fault_o <= 1'b0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            hold <= hold_n;
            inst_o <= inst_n;
            pc_o <= pc_out_n;
            valid_o <= valid_n;
            e_inst_access_fault_o <= fault_n;
        end
    end
endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: scoreboard bench for stage_if with a Wishbone slave model and directed redirects.
module tb_stage_if;
    typedef struct {logic [31:0] pc; logic [31:0] inst; logic fault;} out_t;
    logic clk_i = 1'b0, rst_ni = 1'b0, br_j_taken_i = 1'b0, stall_i = 1'b1;
    logic iwbm_ack_i = 1'b0, iwbm_err_i = 1'b0;
    logic [31:0] br_j_addr_i = '0, iwbm_dat_i = '0;
    logic [31:0] iwbm_addr_o, pc_o, inst_o;
    logic [3:0] iwbm_sel_o;
    logic iwbm_cyc_o, iwbm_stb_o, iwbm_we_o, valid_o, e_inst_access_fault_o;
    int tests = 0, fails = 0, waits = 0, cnt = 0;
    logic [31:0] err_addr = 32'h1;
    logic [31:0] exp_addr[$];
    out_t exp_out[$];
    logic prev_cyc = 1'b0, prev_valid = 1'b0;
    logic [31:0] cur_addr = '0;
    out_t cur;

    stage_if dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .br_j_taken_i(br_j_taken_i), .br_j_addr_i(br_j_addr_i),
        .stall_i(stall_i), .iwbm_addr_o(iwbm_addr_o), .iwbm_cyc_o(iwbm_cyc_o), .iwbm_stb_o(iwbm_stb_o),
        .iwbm_we_o(iwbm_we_o), .iwbm_sel_o(iwbm_sel_o), .iwbm_dat_i(iwbm_dat_i), .iwbm_ack_i(iwbm_ack_i),
        .iwbm_err_i(iwbm_err_i), .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o),
        .e_inst_access_fault_o(e_inst_access_fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // slave: ack (plus err on err_addr) after 'waits' wait states, data = address + 0x100
    always @(posedge clk_i) begin
        #1;
        if (iwbm_cyc_o) begin
            iwbm_ack_i = cnt == waits;
            iwbm_err_i = cnt == waits && iwbm_addr_o == err_addr;
            iwbm_dat_i = iwbm_addr_o + 32'h100;
            cnt++;
        end else begin
            iwbm_ack_i = 1'b0;
            iwbm_err_i = 1'b0;
            cnt = 0;
        end
    end

    always @(negedge clk_i) begin
        if (iwbm_cyc_o && !prev_cyc) begin
            chk("stb", 32'(iwbm_stb_o), 32'd1);
            chk("we_sel", 32'({iwbm_we_o, iwbm_sel_o}), 32'h0F);
            if (exp_addr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL addr_unexpected: got %h, required no request", iwbm_addr_o);
            end else chk("addr", iwbm_addr_o, exp_addr.pop_front());
            cur_addr = iwbm_addr_o;
        end else if (iwbm_cyc_o) chk("addr_hold", iwbm_addr_o, cur_addr);
        if (valid_o && !prev_valid) begin
            chk("valid_no_cyc", 32'(iwbm_cyc_o), 32'd0);
            if (exp_out.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_unexpected: got pc %h inst %h, required no output", pc_o, inst_o);
                cur = '{pc_o, inst_o, e_inst_access_fault_o};
            end else begin
                cur = exp_out.pop_front();
                chk("pc", pc_o, cur.pc);
                chk("inst", inst_o, cur.inst);
                chk("fault", 32'(e_inst_access_fault_o), 32'(cur.fault));
            end
        end else if (valid_o) begin
            chk("pc_hold", pc_o, cur.pc);
            chk("inst_hold", inst_o, cur.inst);
            chk("fault_hold", 32'(e_inst_access_fault_o), 32'(cur.fault));
        end
        prev_cyc = iwbm_cyc_o;
        prev_valid = valid_o;
    end

    task automatic step;
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_o && n < 50) begin
            step();
            n++;
        end
        if (!valid_o) begin
            tests++;
            fails++;
            $display("FAIL valid_timeout: valid_o=0 after %0d cycles, required 1", n);
        end
    endtask

    task automatic consume;
        stall_i = 1'b0;
        step();
        stall_i = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] a);
        br_j_taken_i = 1'b1;
        br_j_addr_i = a;
        step();
        br_j_taken_i = 1'b0;
    endtask

    task automatic push_out(input logic [31:0] p, input logic [31:0] i, input logic f);
        exp_out.push_back('{p, i, f});
    endtask

    initial begin
        int n;
        repeat (3) step();
        chk("rst_cyc", 32'(iwbm_cyc_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_fault", 32'(e_inst_access_fault_o), 32'd0);
        chk("rst_inst", inst_o, 32'h00000013);
        chk("rst_pc", pc_o, 32'h0);
        // zero-wait streaming, then stall, then an erroring fetch
        exp_addr.push_back(32'h80000000); exp_addr.push_back(32'h80000004); exp_addr.push_back(32'h80000008);
        exp_addr.push_back(32'h8000000C); exp_addr.push_back(32'h80000010);
        push_out(32'h80000000, 32'h80000100, 1'b0); push_out(32'h80000004, 32'h80000104, 1'b0);
        push_out(32'h80000008, 32'h80000108, 1'b0); push_out(32'h8000000C, 32'h8000010C, 1'b0);
        push_out(32'h80000010, 32'h00000013, 1'b1);
        err_addr = 32'h80000010;
        rst_ni = 1'b1;
        wait_valid(n); consume();
        wait_valid(n); chk("tput1", 32'(n), 32'd1); consume();
        wait_valid(n); chk("tput2", 32'(n), 32'd1); consume();
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_no_cyc", 32'(iwbm_cyc_o), 32'd0);
        end
        consume();
        wait_valid(n); chk("tput_err", 32'(n), 32'd1);
        exp_addr.push_back(32'h80000100); push_out(32'h80000100, 32'h80000200, 1'b0);
        redirect(32'h80000100);
        wait_valid(n);
        // 3 wait states, redirect in the 2nd wait cycle
        waits = 3;
        exp_addr.push_back(32'h80000104); exp_addr.push_back(32'h80000200);
        push_out(32'h80000200, 32'h80000300, 1'b0);
        consume();
        step();
        redirect(32'h80000200);
        wait_valid(n);
        // redirect in the same cycle as a zero-wait ack, unaligned target
        waits = 0;
        exp_addr.push_back(32'h80000204); exp_addr.push_back(32'h80000040);
        push_out(32'h80000040, 32'h80000140, 1'b0);
        consume();
        redirect(32'h80000043);
        chk("idle_gap_cyc", 32'(iwbm_cyc_o), 32'd0);
        chk("idle_gap_valid", 32'(valid_o), 32'd0);
        step();
        chk("redir_cyc", 32'(iwbm_cyc_o), 32'd1);
        chk("redir_addr", iwbm_addr_o, 32'h80000040);
        wait_valid(n);
        // wrap at the top of the address space
        exp_addr.push_back(32'hFFFFFFFC); exp_addr.push_back(32'h00000000);
        push_out(32'hFFFFFFFC, 32'h000000FC, 1'b0); push_out(32'h00000000, 32'h00000100, 1'b0);
        redirect(32'hFFFFFFFC);
        wait_valid(n); consume();
        wait_valid(n);
        // async reset in the middle of a transfer
        waits = 5;
        exp_addr.push_back(32'h00000004);
        consume();
        step();
        rst_ni = 1'b0;
        #1;
        chk("arst_cyc", 32'(iwbm_cyc_o), 32'd0);
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_inst", inst_o, 32'h00000013);
        chk("arst_pc", pc_o, 32'h0);
        step();
        waits = 0;
        exp_addr.push_back(32'h80000000); push_out(32'h80000000, 32'h80000100, 1'b0);
        rst_ni = 1'b1;
        wait_valid(n);
        repeat (3) step();
        chk("addr_q_empty", 32'(exp_addr.size()), 32'd0);
        chk("out_q_empty", 32'(exp_out.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
